// File: rtl/adc_trigger_capture_if.sv
// Write port into the dual-port waveform RAM.
// The capture block drives it as master; the RAM side listens as slave.
interface adc_trigger_capture_if #(
  parameter int ADDR_W = 8,
  parameter int PIX_W  = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/adc_trigger_capture.sv
// Decimates the ADC stream, waits for a level crossing or timeout, then writes DEPTH pixels to RAM.
// Optional macro TRIG_HYST_EN: a crossing must first be armed by a sample HYST LSBs beyond the level.
module adc_trigger_capture #(
  parameter int ADC_W   = 14,
  parameter int PIX_W   = 8,
  parameter int DEPTH   = 160,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4095,
  parameter int HYST    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  adc_valid,
  input  logic [ADC_W-1:0]      adc_data,
  input  logic [ADC_W-1:0]      trig_level,
  input  logic                  trig_slope,
  input  logic [1:0]            time_division,
  adc_trigger_capture_if.master wr,
  output logic                  triggered,
  output logic                  finished
);

  localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [PIX_W-1:0]  PIX_MAX = '1;

  if (DEPTH > (1 << ADDR_W) || HYST < 0) begin : g_cfg_check
    $error("adc_trigger_capture: DEPTH exceeds address space or HYST negative");
  end

  typedef enum logic [1:0] {IDLE, SEEK, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        td_q, td_d;
  logic [ADC_W-1:0]  level_q, level_d;
  logic              slope_q, slope_d;
  logic [ADC_W-1:0]  prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [2:0]        dec_q, dec_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              triggered_q, triggered_d;
  logic              finished_q, finished_d;

  logic [2:0]        dec_mask;
  logic              running, accept, rise, fall, crossing;
  logic [PIX_W-1:0]  pix;

`ifdef TRIG_HYST_EN
  logic              armed_q, armed_d;
  logic [ADC_W:0]    lvl_ext, hyst_ext, lo_thr, hi_sum, hi_thr;
  logic              arm_now;
`endif

  always_comb begin
    case (td_q)
      2'd0:    dec_mask = 3'd0;
      2'd1:    dec_mask = 3'd1;
      2'd2:    dec_mask = 3'd3;
      default: dec_mask = 3'd7;
    endcase
    running  = (state_q == SEEK) || (state_q == CAPTURE);
    accept   = running && adc_valid && (dec_q == 3'd0);
    rise     = (prev_q < level_q) && (adc_data >= level_q);
    fall     = (prev_q > level_q) && (adc_data <= level_q);
    pix      = PIX_MAX - adc_data[ADC_W-1 -: PIX_W];
`ifdef TRIG_HYST_EN
    // Thresholds are computed one bit wider so both ends can saturate cleanly.
    lvl_ext  = {1'b0, level_q};
    hyst_ext = (ADC_W+1)'(HYST);
    lo_thr   = (lvl_ext >= hyst_ext) ? lvl_ext - hyst_ext : '0;
    hi_sum   = lvl_ext + hyst_ext;
    hi_thr   = (hi_sum > {1'b0, {ADC_W{1'b1}}}) ? {1'b0, {ADC_W{1'b1}}} : hi_sum;
    arm_now  = slope_q ? ({1'b0, adc_data} >= hi_thr) : ({1'b0, adc_data} <= lo_thr);
    crossing = prev_vld_q && armed_q && (slope_q ? fall : rise);
`else
    crossing = prev_vld_q && (slope_q ? fall : rise);
`endif
  end

  always_comb begin
    state_d     = state_q;
    td_d        = td_q;
    level_d     = level_q;
    slope_d     = slope_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    dec_d       = dec_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    triggered_d = triggered_q;
    finished_d  = finished_q;
`ifdef TRIG_HYST_EN
    armed_d     = armed_q;
`endif

    if (running && adc_valid)
      dec_d = (dec_q == dec_mask) ? 3'd0 : dec_q + 3'd1;

    case (state_q)
      IDLE: begin
        finished_d  = 1'b0;
        triggered_d = 1'b0;
        dec_d       = '0;
        tmo_d       = '0;
        addr_d      = '0;
        prev_vld_d  = 1'b0;
`ifdef TRIG_HYST_EN
        armed_d     = 1'b0;
`endif
        if (enable) begin
          td_d    = time_division;
          level_d = trig_level;
          slope_d = trig_slope;
          state_d = SEEK;
        end
      end
      SEEK: begin
        if (accept) begin
`ifdef TRIG_HYST_EN
          if (arm_now) armed_d = 1'b1;
`endif
          // The triggering sample (real or timeout) is itself the first pixel.
          if (crossing || tmo_q == TO_W'(TIMEOUT)) begin
            triggered_d = crossing;
            wr_en_d     = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = pix;
            addr_d      = addr_q + 1'b1;
            state_d     = (addr_q == LAST) ? DONE : CAPTURE;
          end else begin
            prev_d     = adc_data;
            prev_vld_d = 1'b1;
            tmo_d      = tmo_q + 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = pix;
          addr_d    = addr_q + 1'b1;
          if (addr_q == LAST) state_d = DONE;
        end
      end
      DONE: finished_d = 1'b1;
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d     = IDLE;
      wr_en_d     = 1'b0;
      finished_d  = 1'b0;
      triggered_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      td_q        <= '0;
      level_q     <= '0;
      slope_q     <= 1'b0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      dec_q       <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      triggered_q <= 1'b0;
      finished_q  <= 1'b0;
`ifdef TRIG_HYST_EN
      armed_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      td_q        <= td_d;
      level_q     <= level_d;
      slope_q     <= slope_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      dec_q       <= dec_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      triggered_q <= triggered_d;
      finished_q  <= finished_d;
`ifdef TRIG_HYST_EN
      armed_q     <= armed_d;
`endif
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign triggered  = triggered_q;
  assign finished   = finished_q;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Scoreboard bench for adc_trigger_capture: directed captures push expected RAM writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_adc_trigger_capture;
  localparam int ADC_W   = 14;
  localparam int PIX_W   = 8;
  localparam int DEPTH   = 160;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;
  localparam int HYST    = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              adc_valid = 1'b0;
  logic [ADC_W-1:0]  adc_data = '0;
  logic [ADC_W-1:0]  trig_level = '0;
  logic              trig_slope = 1'b0;
  logic [1:0]        time_division = '0;
  logic              triggered, finished;

  adc_trigger_capture_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) wr_if ();

  adc_trigger_capture #(
    .ADC_W(ADC_W), .PIX_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .TIMEOUT(TIMEOUT), .HYST(HYST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_valid(adc_valid),
    .adc_data(adc_data), .trig_level(trig_level), .trig_slope(trig_slope),
    .time_division(time_division), .wr(wr_if), .triggered(triggered),
    .finished(finished)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
    logic              trig;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int unsigned n_checks = 0, n_fail = 0;
  int unsigned wr_count = 0, cyc = 0, last_wr_cyc = 0, exp_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [13:0] d);
    logic [7:0] top;
    top = d[13:6];
    return 8'd255 - top;
  endfunction

  task automatic expect_wr(input int unsigned a, input logic [7:0] d, input logic t);
    exp_q.push_back(wr_t'{addr: ADDR_W'(a), data: d, trig: t});
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && wr_if.wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write at addr %0d data %0d, expected none",
                 wr_if.wr_addr, wr_if.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_if.wr_addr, mon_e.addr);
        check("wr_data", wr_if.wr_data, mon_e.data);
        check("wr_triggered", triggered, mon_e.trig);
        if (exp_gap != 0 && wr_count > 1) check("wr_gap", cyc - last_wr_cyc, exp_gap);
      end
      last_wr_cyc = cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ADC_W-1:0] d, input int unsigned gap);
    adc_valid = 1'b1;
    adc_data  = d;
    tick();
    adc_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic start(input logic [ADC_W-1:0] lvl, input logic slope, input logic [1:0] td);
    trig_level    = lvl;
    trig_slope    = slope;
    time_division = td;
    enable        = 1'b1;
    tick();
    tick();
  endtask

  task automatic finish_capture(input string name);
    int unsigned n = 0;
    while (!finished && n < 3000) begin
      tick();
      n++;
    end
    check({name, " finished"}, finished, 1);
    check({name, " write_count"}, wr_count, DEPTH);
    check({name, " queue_empty"}, exp_q.size(), 0);
    send(14'd100, 0);
    send(14'd9000, 1);
    check({name, " done_hold"}, finished, 1);
    check({name, " done_no_write"}, wr_count, DEPTH);
    enable = 1'b0;
    tick();
    check({name, " abort_finished"}, finished, 0);
    check({name, " abort_triggered"}, triggered, 0);
    wr_count = 0;
    exp_gap  = 0;
    tick();
  endtask

  logic [13:0] d;
  logic [13:0] h_s [4];
  logic [7:0]  h_p [4];
  int unsigned trig_idx;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst wr_en", wr_if.wr_en, 0);
    check("rst wr_addr", wr_if.wr_addr, 0);
    check("rst wr_data", wr_if.wr_data, 0);
    check("rst triggered", triggered, 0);
    check("rst finished", finished, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle finished", finished, 0);

    // Rising, td=0, ramp 8000 step 100; 8200 crosses 8192
    start(14'd8192, 1'b0, 2'd0);
    for (int unsigned k = 0; k < 162; k++) begin
      d = 14'(8000 + 100 * k);
      if (k == 2) expect_wr(0, 8'd127, 1'b1);
      else if (k > 2) expect_wr(k - 2, pix(d), 1'b1);
      send(d, 0);
    end
    finish_capture("rising");

    // Decimation td=2, constant 0, auto-trigger on the 5th accepted sample
    exp_gap = 4;
    start(14'd0, 1'b0, 2'd2);
    for (int unsigned i = 0; i < 656; i++) begin
      if (i % 4 == 0 && i / 4 >= 4) expect_wr(i / 4 - 4, 8'd255, 1'b0);
      send(14'd0, 0);
    end
    finish_capture("decimation");

    // Falling slope with gaps between samples
    start(14'd4096, 1'b1, 2'd0);
    send(14'd5000, 2);
    expect_wr(0, 8'd209, 1'b1);
    send(14'd3000, 2);
    for (int unsigned k = 1; k < DEPTH; k++) begin
      expect_wr(k, 8'd209, 1'b1);
      send(14'd3000, 1);
    end
    finish_capture("falling");

    // Abort at write address 50, pending write dropped, then restart
    start(14'd8192, 1'b0, 2'd0);
    send(14'd8000, 0);
    for (int unsigned a = 0; a <= 50; a++) begin
      expect_wr(a, 8'd126, 1'b1);
      send(14'd8300, 0);
    end
    check("abort pre wr_en", wr_if.wr_en, 1);
    check("abort pre wr_addr", wr_if.wr_addr, 50);
    enable    = 1'b0;
    adc_valid = 1'b1;
    adc_data  = 14'd8300;
    tick();
    adc_valid = 1'b0;
    check("abort wr_en", wr_if.wr_en, 0);
    check("abort finished", finished, 0);
    check("abort triggered", triggered, 0);
    tick();
    check("abort write_count", wr_count, 51);
    check("abort queue_empty", exp_q.size(), 0);
    wr_count = 0;
    start(14'd8192, 1'b0, 2'd0);
    send(14'd8000, 0);
    for (int unsigned a = 0; a < DEPTH; a++) begin
      expect_wr(a, 8'd126, 1'b1);
      send(14'd8300, 0);
    end
    finish_capture("restart");

    // Async reset mid-capture, off the clock edge
    start(14'd8192, 1'b0, 2'd0);
    send(14'd8000, 0);
    for (int unsigned a = 0; a < 21; a++) begin
      expect_wr(a, 8'd126, 1'b1);
      send(14'd8300, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("areset wr_en", wr_if.wr_en, 0);
    check("areset wr_addr", wr_if.wr_addr, 0);
    check("areset wr_data", wr_if.wr_data, 0);
    check("areset triggered", triggered, 0);
    check("areset finished", finished, 0);
    exp_q.delete();
    enable = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset finished", finished, 0);
    check("post_reset wr_en", wr_if.wr_en, 0);
    wr_count = 0;

    // Hysteresis pattern: 8150, 8200, 8100, 8200 then 8200 filler
    h_s[0] = 14'd8150; h_p[0] = 8'd128;
    h_s[1] = 14'd8200; h_p[1] = 8'd127;
    h_s[2] = 14'd8100; h_p[2] = 8'd129;
    h_s[3] = 14'd8200; h_p[3] = 8'd127;
`ifdef TRIG_HYST_EN
    trig_idx = 3;
`else
    trig_idx = 1;
`endif
    start(14'd8192, 1'b0, 2'd0);
    for (int unsigned k = 0; k < 163; k++) begin
      if (k >= trig_idx && k - trig_idx < DEPTH)
        expect_wr(k - trig_idx, (k < 4) ? h_p[k] : 8'd127, 1'b1);
      send((k < 4) ? h_s[k] : 14'd8200, 0);
    end
    finish_capture("hysteresis");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
